// File: rtl/corefifo_pkg.sv
// Shared FIFO pointer helpers. The write-side and read-side pointer blocks both
// use these functions so that their gray encoding is identical.
package corefifo_pkg;

  // Widest pointer the helpers handle; callers zero-extend and cast back down.
  localparam int MAXW = 32;

  typedef logic [MAXW-1:0] ptr_ext_t;

  // Registered status bits of the write side.
  typedef struct packed {
    logic full;
    logic afull;
    logic ack;
    logic ovf;
  } wr_status_t;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptrw(input int addrwidth);
    return addrwidth + 1;
  endfunction

  function automatic ptr_ext_t bin2gray(input ptr_ext_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended gray input decodes correctly because the leading zeros
  // leave the prefix xor unchanged.
  function automatic ptr_ext_t gray2bin(input ptr_ext_t g);
    ptr_ext_t r;
    r[MAXW-1] = g[MAXW-1];
    for (int i = MAXW - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ g[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/corefifo_wr_ptr_gray_if.sv
// Write-side FIFO pointer bundle. The slave modport is the pointer block;
// the master modport is whoever issues writes and supplies the synced read pointer.
interface corefifo_wr_ptr_gray_if #(
  parameter int ADDRWIDTH = 3
);
  import corefifo_pkg::*;

  localparam int PW = ptrw(ADDRWIDTH);

  logic                 wr_en;
  logic [PW-1:0]        rd_ptr_gray_sync;
  logic [ADDRWIDTH-1:0] wr_addr;
  logic [PW-1:0]        wr_ptr_bin;
  logic [PW-1:0]        wr_ptr_gray;
  logic                 wr_we;
  logic                 full;
  logic                 afull;
  logic [PW-1:0]        wrcnt;
  logic                 wr_ack;
  logic                 overflow;

  modport slave (
    input  wr_en, rd_ptr_gray_sync,
    output wr_addr, wr_ptr_bin, wr_ptr_gray, wr_we, full, afull, wrcnt,
           wr_ack, overflow
  );

  modport master (
    output wr_en, rd_ptr_gray_sync,
    input  wr_addr, wr_ptr_bin, wr_ptr_gray, wr_we, full, afull, wrcnt,
           wr_ack, overflow
  );

endinterface

// File: rtl/corefifo_gray2bin_comb.sv
// Purely combinational gray-to-binary decode of a synchronized pointer.
module corefifo_gray2bin_comb
  import corefifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Prefix xor from the MSB down, shared with the read-side block.
  always_comb begin
    bin_o = W'(gray2bin(ptr_ext_t'(gray_i)));
  end

endmodule

// File: rtl/corefifo_wr_ptr_gray.sv
// Write-side pointer generator: binary write pointer, registered gray pointer
// for the read domain, and full/almost-full/fill status against the synced
// read pointer.
module corefifo_wr_ptr_gray
  import corefifo_pkg::*;
#(
  parameter int ADDRWIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  corefifo_wr_ptr_gray_if.slave   bus
);

  localparam int            PW        = ptrw(ADDRWIDTH);
  localparam logic [PW-1:0] FULL_LVL  = {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wr_ptr_bin_q, next_bin_d;
  logic [PW-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [PW-1:0] wrcnt_q, diff_d;
  logic [PW-1:0] rd_bin;
  wr_status_t    status_q, status_d;
  logic          accept;

  corefifo_gray2bin_comb #(.W(PW)) u_rd_dec (
    .gray_i (bus.rd_ptr_gray_sync),
    .bin_o  (rd_bin)
  );

  // Next pointer, its gray image and the status that will be true after this edge.
  always_comb begin
    accept         = bus.wr_en & ~status_q.full;
    next_bin_d     = accept ? wr_ptr_bin_q + PW'(1) : wr_ptr_bin_q;
    wr_ptr_gray_d  = PW'(bin2gray(ptr_ext_t'(next_bin_d)));
    diff_d         = next_bin_d - rd_bin;
    status_d.full  = (diff_d == FULL_LVL);
    status_d.afull = (diff_d >= AFULL_LVL);
    status_d.ack   = accept;
    status_d.ovf   = bus.wr_en & status_q.full;
  end

  // Pointer and status registers; reset drops everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      wrcnt_q       <= '0;
      status_q      <= '0;
    end else begin
      wr_ptr_bin_q  <= next_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      wrcnt_q       <= diff_d;
      status_q      <= status_d;
    end
  end

  assign bus.wr_addr     = wr_ptr_bin_q[ADDRWIDTH-1:0];
  assign bus.wr_ptr_bin  = wr_ptr_bin_q;
  assign bus.wr_ptr_gray = wr_ptr_gray_q;
  assign bus.wr_we       = accept;
  assign bus.full        = status_q.full;
  assign bus.afull       = status_q.afull;
  assign bus.wrcnt       = wrcnt_q;
  assign bus.wr_ack      = status_q.ack;
  assign bus.overflow    = status_q.ovf;

endmodule
